sysid_reader: RTL
=================

Name: sysid_reader

Overview:
- Avalon-MM master that reads the system ID peripheral's two 32-bit registers: word 0 is the ID and word 1 is the build timestamp.
- Compares both values against expected build constants and reports pass/fail plus the captured values.
- Sits between the boot/status logic and the interconnect, so hardware can refuse to enable downstream blocks when the FPGA image and the software build are mismatched.
- Handles waitrequest stalls, variable read latency via readdatavalid, and a bounded response timeout.

Parameters:
- EXPECTED_ID, 0, value required at word 0.
- EXPECTED_TIMESTAMP, 1370544064, value required at word 1.
- ADDR_W, 1, width of master_address (word address).
- BASE_WORD, 0, word address of the ID register; timestamp register is at BASE_WORD+1.
- TIMEOUT_CYCLES, 255, maximum cycles allowed per transaction (request through data); range 1..65535.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a check sequence; ignored while busy=1.
- master_address  out  ADDR_W  word address of the current read.
- master_read  out  1  read request; held until a cycle with waitrequest=0.
- master_waitrequest  in  1  slave stall.
- master_readdatavalid  in  1  read data valid strobe.
- master_readdata  in  32  read data.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when the sequence ends (pass, fail or timeout).
- id_value  out  32  captured ID word.
- timestamp_value  out  32  captured timestamp word.
- id_ok  out  1  id_value == EXPECTED_ID; valid from done until the next start.
- ts_ok  out  1  timestamp_value == EXPECTED_TIMESTAMP; same validity as id_ok.
- timeout  out  1  sticky; the last sequence aborted on timeout.

Behaviour:
- Reset values:
  - master_read=0, master_address=BASE_WORD.
  - busy=0, done=0, id_ok=0, ts_ok=0, timeout=0.
  - id_value=0, timestamp_value=0.
  - Timeout counter=0; state=IDLE.
- Reset mid-sequence aborts immediately with the same values; no done pulse.
- IDLE:
  - start=1 moves to REQ_ID on the next edge.
  - On that edge: busy=1, master_read=1, master_address=BASE_WORD; clear id_ok, ts_ok and timeout; counter=0.
- REQ_ID:
  - Hold master_read and master_address stable while waitrequest=1.
  - On a cycle with waitrequest=0 the command is accepted: drop master_read next cycle and go to WAIT_ID.
  - If readdatavalid=1 in that same cycle (zero-latency slave), capture the data and go directly to REQ_TS.
- WAIT_ID:
  - On readdatavalid=1, capture master_readdata into id_value.
  - Go to REQ_TS: master_read=1, master_address=BASE_WORD+1, counter=0.
- REQ_TS / WAIT_TS: mirror REQ_ID / WAIT_ID. The capture goes to timestamp_value, then the FSM enters DONE.
- DONE (one cycle):
  - done=1; id_ok and ts_ok updated from the registered captures; busy=0.
  - Return to IDLE.
  - A start in this cycle is ignored.
- Back-to-back:
  - A start in the IDLE cycle right after DONE is accepted.
  - Minimum sequence is 6 cycles from start to done with a zero-wait, one-latency slave: start edge → REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE.
- Timeout:
  - The counter increments each cycle in any REQ_*/WAIT_* state and resets to 0 on each state change.
  - When the counter reaches TIMEOUT_CYCLES without progress: master_read=0, timeout=1, id_ok=0, ts_ok=0, go to DONE (done pulses).
  - Captured values keep whatever was already captured; the uncaptured word is unchanged.
  - A readdatavalid arriving after a timeout, while in IDLE, is ignored.
- Stray readdatavalid:
  - Ignored in IDLE and REQ_* states.
  - Exception: the REQ_* acceptance cycle, as noted under REQ_ID.
- Only one outstanding read at a time; the block never pipelines.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Shared package sysid_pkg holds:
  - the state enum (IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE);
  - the register offset constants ID_OFS=0 and TS_OFS=1;
  - the default expected constants.
- One natural sub-module, avalon_read_timer: the per-transaction cycle counter with clear, enable and expired outputs, parameterised by TIMEOUT_CYCLES.
- The FSM and capture registers stay in sysid_reader.

Test Plan:
- Responder with waitrequest=0, latency 1, words 0 / 1370544064; pulse start → done at cycle 6 with id_ok=1, ts_ok=1, timeout=0, timestamp_value=1370544064.
- Responder returns timestamp 1370544065 → done with id_ok=1, ts_ok=0, timestamp_value=1370544065.
- waitrequest held high 3 cycles on each request, latency 2 → master_read and master_address stable throughout; done at cycle 14; both ok.
- readdatavalid never asserted for the timestamp read, TIMEOUT_CYCLES=8 → done with timeout=1, id_ok=0, ts_ok=0, id_value=0.
- Second start pulsed while busy, plus a stray readdatavalid in IDLE → both ignored; exactly one done; captured values unchanged.
- reset asserted for 1 cycle while in WAIT_TS → all outputs at reset values the next cycle; no done; a new start then completes normally.

Source files
------------

// File: rtl/sysid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sysid_pkg                                                       |
// | Brief    : Shared states, register offsets and expected build constants.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int unsigned ID_OFS = 0;
    localparam int unsigned TS_OFS = 1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1370544064;

endpackage
`default_nettype wire

// File: rtl/avalon_read_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : avalon_read_timer                                               |
// | Brief    : Per-transaction cycle counter with clear, enable and expiry.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module avalon_read_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // Expiry fires on the TIMEOUT_CYCLES-th enabled cycle since the last clear.
    localparam logic [15:0] c_limit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_limit)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expired = i_enable && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/sysid_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sysid_reader                                                    |
// | Brief    : Avalon-MM master reading and checking the system ID registers.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sysid_reader
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int unsigned ADDR_W             = 1,
    parameter int unsigned BASE_WORD          = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic              master_waitrequest,
    input  logic              master_readdatavalid,
    input  logic [31:0]       master_readdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       id_value,
    output logic [31:0]       timestamp_value,
    output logic              id_ok,
    output logic              ts_ok,
    output logic              timeout
);

    localparam logic [ADDR_W-1:0] c_id_addr = ADDR_W'(BASE_WORD + ID_OFS);
    localparam logic [ADDR_W-1:0] c_ts_addr = ADDR_W'(BASE_WORD + TS_OFS);

    state_t            r_state;
    logic              r_read;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_id_value;
    logic [31:0]       r_ts_value;
    logic              r_id_ok;
    logic              r_ts_ok;
    logic              r_timeout;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_next;
    logic              w_read_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic [31:0]       w_id_next;
    logic [31:0]       w_ts_next;
    logic              w_id_ok_next;
    logic              w_ts_ok_next;
    logic              w_timeout_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_finish;
    logic              w_abort;
    logic              w_timer_en;
    logic              w_timer_clr;
    logic              w_expired;

    assign w_timer_en  = r_state inside {REQ_ID, WAIT_ID, REQ_TS, WAIT_TS};
    assign w_timer_clr = (w_state_next != r_state);

    avalon_read_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clock),
        .rst      (reset),
        .i_clear  (w_timer_clr),
        .i_enable (w_timer_en),
        .o_expired(w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_read     <= 1'b0;
            r_addr     <= c_id_addr;
            r_id_value <= '0;
            r_ts_value <= '0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_read     <= w_read_next;
            r_addr     <= w_addr_next;
            r_id_value <= w_id_next;
            r_ts_value <= w_ts_next;
            r_id_ok    <= w_id_ok_next;
            r_ts_ok    <= w_ts_ok_next;
            r_timeout  <= w_timeout_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_read_next    = r_read;
        w_addr_next    = r_addr;
        w_id_next      = r_id_value;
        w_ts_next      = r_ts_value;
        w_id_ok_next   = r_id_ok;
        w_ts_ok_next   = r_ts_ok;
        w_timeout_next = r_timeout;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_finish       = 1'b0;
        w_abort        = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next   = REQ_ID;
                    w_read_next    = 1'b1;
                    w_addr_next    = c_id_addr;
                    w_id_ok_next   = 1'b0;
                    w_ts_ok_next   = 1'b0;
                    w_timeout_next = 1'b0;
                    w_busy_next    = 1'b1;
                end
            end
            REQ_ID: begin
                // A zero-latency slave may return data in the acceptance cycle.
                if (!master_waitrequest && master_readdatavalid) begin
                    w_id_next    = master_readdata;
                    w_state_next = REQ_TS;
                    w_addr_next  = c_ts_addr;
                end else if (!master_waitrequest) begin
                    w_read_next  = 1'b0;
                    w_state_next = WAIT_ID;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            WAIT_ID: begin
                if (master_readdatavalid) begin
                    w_id_next    = master_readdata;
                    w_state_next = REQ_TS;
                    w_read_next  = 1'b1;
                    w_addr_next  = c_ts_addr;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            REQ_TS: begin
                if (!master_waitrequest && master_readdatavalid) begin
                    w_ts_next = master_readdata;
                    w_finish  = 1'b1;
                end else if (!master_waitrequest) begin
                    w_read_next  = 1'b0;
                    w_state_next = WAIT_TS;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            WAIT_TS: begin
                if (master_readdatavalid) begin
                    w_ts_next = master_readdata;
                    w_finish  = 1'b1;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Verdicts use the values being captured on this edge so they are valid with done.
        if (w_finish) begin
            w_state_next = DONE;
            w_read_next  = 1'b0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_id_ok_next = (w_id_next == EXPECTED_ID);
            w_ts_ok_next = (w_ts_next == EXPECTED_TIMESTAMP);
        end
        if (w_abort) begin
            w_state_next   = DONE;
            w_read_next    = 1'b0;
            w_busy_next    = 1'b0;
            w_done_next    = 1'b1;
            w_timeout_next = 1'b1;
            w_id_ok_next   = 1'b0;
            w_ts_ok_next   = 1'b0;
        end
    end

    assign master_address  = r_addr;
    assign master_read     = r_read;
    assign busy            = r_busy;
    assign done            = r_done;
    assign id_value        = r_id_value;
    assign timestamp_value = r_ts_value;
    assign id_ok           = r_id_ok;
    assign ts_ok           = r_ts_ok;
    assign timeout         = r_timeout;

endmodule
`default_nettype wire
